regdump_streamer: RTL and testbench
===================================

Name: regdump_streamer

Overview:
- Synthesizable, parametrised successor to simulation-only register/memory dumping.
- On a start pulse, it scans NUM_ENTRIES words through a synchronous read port (CPU register file debug port or text char memory).
- Each word is formatted as an ASCII hex line, "<index>:<data>\n", and streamed as bytes over a valid/ready interface, normally into the UART TX.
- Sits between the debug read ports and uart_tx in top.

Parameters:
- DATA_WIDTH, 32, width of each read word; must be a multiple of 4.
- ADDR_WIDTH, 5, width of rd_addr.
- NUM_ENTRIES, 32, words dumped per run (1..2^ADDR_WIDTH).
- HEX_DIGITS, DATA_WIDTH/4, derived: data characters per line.
- IDX_DIGITS, (ADDR_WIDTH+3)/4, derived: index characters per line.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a dump
- abort  in  1  terminate the current dump at the next byte boundary
- busy  out  1  high from the cycle after start is accepted until the done cycle inclusive
- done  out  1  one-cycle pulse when the dump finishes or is aborted
- rd_en  out  1  read strobe
- rd_addr  out  ADDR_WIDTH  read address
- rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after rd_en
- tx_data  out  8  ASCII byte
- tx_valid  out  1  byte available
- tx_ready  in  1  sink accepts the byte

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, tx_data=0, tx_valid=0, FSM=IDLE, entry counter=0. Reset is asynchronous and may arrive mid-byte; tx_valid drops immediately, with no partial-line recovery.
- FSM states: IDLE, READ, CAPTURE, EMIT_IDX, EMIT_COLON, EMIT_DATA, EMIT_NL, DONE.
- IDLE:
  - start=1 -> READ, entry=0.
  - start while busy is ignored.
  - abort in IDLE is ignored.
- READ: rd_en=1 and rd_addr=entry for exactly one cycle -> CAPTURE.
- CAPTURE: latch rd_data into a shift register; load the index nibble counter -> EMIT_IDX.
- EMIT_IDX:
  - Emits IDX_DIGITS characters, MS nibble first, taken from entry zero-extended to IDX_DIGITS*4 bits.
  - Then -> EMIT_COLON (0x3A) -> EMIT_DATA.
- EMIT_DATA: emits HEX_DIGITS characters, MS nibble first -> EMIT_NL (0x0A).
- Hex encoding: 0-9 -> 0x30-0x39; A-F -> 0x41-0x46 (uppercase).
- After NL is accepted:
  - If entry==NUM_ENTRIES-1 -> DONE.
  - Otherwise entry+1 -> READ.
  - No wrap-around past NUM_ENTRIES-1.
- DONE: done=1 for one cycle, busy=1 during that cycle -> IDLE.
- Handshake (AXI-stream style):
  - A byte transfers on a cycle with tx_valid && tx_ready.
  - Once tx_valid is raised, tx_data is held stable and tx_valid stays high until the transfer.
  - Each emit state presents its byte registered. The next byte may be presented in the cycle after a transfer (one byte per cycle max with tx_ready tied high), or the emitter may wait a cycle.
  - Throughput with tx_ready=1: exactly IDX_DIGITS+HEX_DIGITS+2 cycles per line, plus 2 cycles (READ, CAPTURE) per entry.
  - tx_ready low stalls the FSM indefinitely; there is no timeout.
- Abort:
  - Latched into a sticky flag while busy.
  - Takes effect only when tx_valid=0, or in the cycle the current byte transfers. Never drops tx_valid without a transfer.
  - Then -> DONE. The remaining bytes and the newline are not sent.
  - Abort and start in the same cycle in IDLE: start wins, and the abort is discarded.
- Bytes per full dump: NUM_ENTRIES*(IDX_DIGITS+HEX_DIGITS+2). Defaults: 32*12 = 384.

Test Plan:
- Defaults, tx_ready=1; regs x0=0x00000000, x1=0xDEADBEEF, xk=k. Start -> first 24 bytes "00:00000000\n01:DEADBEEF\n"; 384 bytes total; done pulses once; busy low the cycle after done.
- NUM_ENTRIES=4, ADDR_WIDTH=2, DATA_WIDTH=8, data {0x0A,0xFF,0x10,0x3C}.
  - Required stream: "0:0A\n1:FF\n2:10\n3:3C\n" (20 bytes).
  - Each line takes 5 transfer cycles + 2 read cycles.
  - rd_en pulses exactly 4 times, at addresses 0,1,2,3.
- Backpressure: tx_ready random 30% duty -> identical byte sequence to the tx_ready=1 run; tx_data and tx_valid never change while tx_valid && !tx_ready (assertion).
- Abort: with tx_ready held low while byte 5 of line 2 is presented, assert abort. Then release tx_ready -> that byte transfers, then done pulses; no further bytes; next start dumps from entry 0.
- Start while busy: pulse start mid-dump -> ignored; a single 384-byte dump and a single done pulse.
- Reset mid-dump: drop resetn while tx_valid=1 -> tx_valid, busy and rd_en go 0 asynchronously; after release, FSM is IDLE; a new start produces the full stream from "00:".

Source files
------------

// File: rtl/regdump_streamer.sv
// Scans NUM_ENTRIES words through a synchronous read port and streams each one
// as an ASCII hex line "<index>:<data>\n" over a valid/ready byte interface.
module regdump_streamer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned NUM_ENTRIES = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int unsigned HEX_DIGITS = DATA_WIDTH / 4;
  localparam int unsigned IDX_DIGITS = (ADDR_WIDTH + 3) / 4;
  localparam int unsigned IDX_W      = IDX_DIGITS * 4;
  localparam int unsigned CNT_W      = $clog2(HEX_DIGITS + IDX_DIGITS + 1);

  typedef enum logic [2:0] {
    IDLE, READ, CAPTURE, EMIT_IDX, EMIT_COLON, EMIT_DATA, EMIT_NL, DONE
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] entry;
  logic [DATA_WIDTH-1:0] data_sh;
  logic [IDX_W-1:0]      idx_sh;
  logic [IDX_W-1:0]      idx_ext;
  logic [CNT_W-1:0]      nib_cnt;
  logic                  abort_flag;
  logic                  abort_eff;
  logic                  xfer;
  logic                  last_entry;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  always_comb begin
    xfer       = tx_valid & tx_ready;
    abort_eff  = abort_flag | abort;
    last_entry = (entry == ADDR_WIDTH'(NUM_ENTRIES - 1));
    idx_ext    = IDX_W'(entry);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Emit states only leave on a transfer, so an abort never retracts a byte.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (start) state_next = READ;
      READ:       state_next = abort_eff ? DONE : CAPTURE;
      CAPTURE:    state_next = abort_eff ? DONE : EMIT_IDX;
      EMIT_IDX:   if (xfer) state_next = abort_eff ? DONE :
                                         ((nib_cnt == '0) ? EMIT_COLON : EMIT_IDX);
      EMIT_COLON: if (xfer) state_next = abort_eff ? DONE : EMIT_DATA;
      EMIT_DATA:  if (xfer) state_next = abort_eff ? DONE :
                                         ((nib_cnt == '0) ? EMIT_NL : EMIT_DATA);
      EMIT_NL:    if (xfer) state_next = (abort_eff || last_entry) ? DONE : READ;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    rd_en   = (state == READ);
    rd_addr = entry;
  end

  // Each byte is loaded on the edge that leaves the previous one, so with
  // tx_ready high a new character is presented every cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entry      <= '0;
      data_sh    <= '0;
      idx_sh     <= '0;
      nib_cnt    <= '0;
      abort_flag <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
    end else begin
      if (state == DONE)      abort_flag <= 1'b0;
      else if (busy && abort) abort_flag <= 1'b1;

      case (state)
        IDLE: if (start) entry <= '0;
        CAPTURE: if (!abort_eff) begin
          data_sh  <= rd_data;
          idx_sh   <= idx_ext << 4;
          nib_cnt  <= CNT_W'(IDX_DIGITS - 1);
          tx_data  <= hex_char(idx_ext[IDX_W-1 -: 4]);
          tx_valid <= 1'b1;
        end
        EMIT_IDX: if (xfer) begin
          if (abort_eff) begin
            tx_valid <= 1'b0;
          end else if (nib_cnt == '0) begin
            tx_data <= 8'h3A;
          end else begin
            tx_data <= hex_char(idx_sh[IDX_W-1 -: 4]);
            idx_sh  <= idx_sh << 4;
            nib_cnt <= nib_cnt - 1'b1;
          end
        end
        EMIT_COLON: if (xfer) begin
          if (abort_eff) begin
            tx_valid <= 1'b0;
          end else begin
            tx_data <= hex_char(data_sh[DATA_WIDTH-1 -: 4]);
            data_sh <= data_sh << 4;
            nib_cnt <= CNT_W'(HEX_DIGITS - 1);
          end
        end
        EMIT_DATA: if (xfer) begin
          if (abort_eff) begin
            tx_valid <= 1'b0;
          end else if (nib_cnt == '0) begin
            tx_data <= 8'h0A;
          end else begin
            tx_data <= hex_char(data_sh[DATA_WIDTH-1 -: 4]);
            data_sh <= data_sh << 4;
            nib_cnt <= nib_cnt - 1'b1;
          end
        end
        EMIT_NL: if (xfer) begin
          tx_valid <= 1'b0;
          if (!abort_eff && !last_entry) entry <= entry + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regdump_streamer.sv
// Directed bench for regdump_streamer: default 32x32 dump and a 4x8 instance,
// with backpressure, abort, restart-while-busy and asynchronous reset.
module tb_regdump_streamer;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic ready_fixed = 1'b1, rand_ready = 1'b0, rnd_bit = 1'b0;
  logic tx_ready;
  logic busy, done, rd_en, tx_valid;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;

  logic start_s = 1'b0, abort_s = 1'b0, ready_s = 1'b1;
  logic busy_s, done_s, rd_en_s, tx_valid_s;
  logic [1:0] rd_addr_s;
  logic [7:0] rd_data_s, tx_data_s;
  logic [7:0] mem_s [4] = '{8'h0A, 8'hFF, 8'h10, 8'h3C};

  int vectors = 0, miscompares = 0;
  int done_cnt = 0, done_s_cnt = 0;
  logic [7:0] rx[$], rx_s[$], exp_q[$];
  int rda_s[$];
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  string HEXS = "0123456789ABCDEF";

  always #5 clk = ~clk;
  always @(negedge clk) rnd_bit = ($urandom_range(0, 9) < 3);
  assign tx_ready = rand_ready ? rnd_bit : ready_fixed;

  regdump_streamer dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  regdump_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_ENTRIES(4)) dut_s (
    .clk(clk), .resetn(resetn), .start(start_s), .abort(abort_s),
    .busy(busy_s), .done(done_s), .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
    .tx_data(tx_data_s), .tx_valid(tx_valid_s), .tx_ready(ready_s)
  );

  function automatic logic [31:0] reg_val(input int k);
    return (k == 1) ? 32'hDEADBEEF : 32'(k);
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= reg_val(int'(rd_addr));
  always @(posedge clk) if (rd_en_s) rd_data_s <= mem_s[rd_addr_s];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (resetn && prev_stall) begin
      chk("hold_valid", tx_valid, 1);
      chk("hold_data", tx_data, prev_data);
    end
    prev_stall = resetn && tx_valid && !tx_ready;
    prev_data  = tx_data;
    if (tx_valid && tx_ready) rx.push_back(tx_data);
    if (done) done_cnt++;
    if (tx_valid_s && ready_s) rx_s.push_back(tx_data_s);
    if (done_s) done_s_cnt++;
    if (rd_en_s) rda_s.push_back(int'(rd_addr_s));
  end

  function automatic void add_line(input int idx, input int nidx, input logic [31:0] val, input int ndat);
    for (int i = nidx - 1; i >= 0; i--) exp_q.push_back(HEXS[(idx >> (4 * i)) & 15]);
    exp_q.push_back(8'h3A);
    for (int i = ndat - 1; i >= 0; i--) exp_q.push_back(HEXS[int'((val >> (4 * i)) & 32'hF)]);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic full_dump(input string tag, input int exp_cycles, input int restart_at);
    int cyc;
    logic last_done;
    rx.delete();
    exp_q.delete();
    done_cnt = 0;
    for (int k = 0; k < 32; k++) add_line(k, 2, reg_val(k), 8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_rise"}, busy, 1);
    cyc = 0;
    last_done = 1'b0;
    while (busy && cyc < 20000) begin
      cyc++;
      last_done = done;
      start = (cyc == restart_at);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " timeout"}, (cyc >= 20000), 0);
    if (exp_cycles >= 0) chk({tag, " busy_cycles"}, cyc, exp_cycles);
    chk({tag, " done_in_last_busy"}, last_done, 1);
    chk({tag, " done_count"}, done_cnt, 1);
    chk({tag, " byte_count"}, rx.size(), 384);
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++)
      chk($sformatf("%s byte %0d", tag, i), rx[i], exp_q[i]);
  endtask

  initial begin
    int cyc;
    string exp_s;
    logic [7:0] e;

    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst rd_en", rd_en, 0);
    chk("rst rd_addr", rd_addr, 0);
    chk("rst tx_data", tx_data, 0);
    chk("rst tx_valid", tx_valid, 0);
    chk("rst busy_s", busy_s, 0);
    resetn = 1'b1;
    @(negedge clk);

    full_dump("plain", 449, -1);

    // 4 x 8-bit instance
    rx_s.delete();
    rda_s.delete();
    done_s_cnt = 0;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    cyc = 0;
    while (busy_s && cyc < 1000) begin
      cyc++;
      @(negedge clk);
    end
    chk("small busy_cycles", cyc, 29);
    chk("small done_count", done_s_cnt, 1);
    chk("small byte_count", rx_s.size(), 20);
    exp_s = "0:0A\n1:FF\n2:10\n3:3C\n";
    for (int i = 0; i < rx_s.size() && i < 20; i++) begin
      e = exp_s[i];
      chk($sformatf("small byte %0d", i), rx_s[i], e);
    end
    chk("small rd_count", rda_s.size(), 4);
    for (int i = 0; i < rda_s.size() && i < 4; i++)
      chk($sformatf("small rd_addr %0d", i), rda_s[i], i);

    rand_ready = 1'b1;
    full_dump("backpressure", -1, -1);
    rand_ready = 1'b0;
    ready_fixed = 1'b1;

    full_dump("restart_ignored", 449, 100);

    // abort while the 'E' of "01:DEADBEEF" is stalled
    rx.delete();
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (rx.size() < 16 && cyc < 1000) begin
      cyc++;
      @(negedge clk);
    end
    chk("abort reach", rx.size(), 16);
    ready_fixed = 1'b0;
    abort = 1'b1;
    chk("abort presented", tx_data, 8'h45);
    chk("abort valid", tx_valid, 1);
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort stall valid", tx_valid, 1);
    chk("abort stall data", tx_data, 8'h45);
    chk("abort stall count", rx.size(), 16);
    chk("abort stall done", done, 0);
    ready_fixed = 1'b1;
    @(negedge clk);
    chk("abort last byte", rx.size(), 17);
    chk("abort done", done, 1);
    chk("abort busy_in_done", busy, 1);
    chk("abort valid_dropped", tx_valid, 0);
    @(negedge clk);
    chk("abort busy_after", busy, 0);
    repeat (5) @(negedge clk);
    chk("abort no_more_bytes", rx.size(), 17);
    chk("abort done_count", done_cnt, 1);
    if (rx.size() > 16) chk("abort final byte", rx[16], 8'h45);

    full_dump("post_abort", 449, -1);

    // asynchronous reset in the middle of the third line
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst pre_valid", tx_valid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("midrst tx_valid", tx_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst rd_en", rd_en, 0);
    chk("midrst rd_addr", rd_addr, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst idle busy", busy, 0);
    chk("midrst idle valid", tx_valid, 0);

    full_dump("post_reset", 449, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
